ram_arbiter: RTL and testbench

- Shares the single byte-addressed RAM port (readReq/writeReq/ramAddress/ramOut/ramValue style) between two requesters.
- Port 0 is the ALU core; port 1 is a secondary master (UART loader / DMA).
- Round-robin arbitration, one transaction in flight, registered strobes toward RAM, registered ack/data back to requesters.
- RAM model: a read strobe high at posedge N produces valid read data from posedge N onward, i.e. one-cycle registered read.

---
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single registered-read RAM port
// Optional RAM_ARB_LOCK_EN: a port holding lockN keeps the grant across back-to-back transactions.
module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic              lat_we;
  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner if a grant happens this cycle; only consulted in IDLE when a req is up.
  always_comb begin
    gnt = (req0 && req1) ? ~last_grant : req1;
`ifdef RAM_ARB_LOCK_EN
    if ((last_grant ? lock1 : lock0) && (last_grant ? req1 : req0))
      gnt = last_grant;
`endif
    sel_we    = gnt ? we1 : we0;
    sel_addr  = gnt ? addr1 : addr0;
    sel_wdata = gnt ? wdata1 : wdata0;
  end

`ifndef RAM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      busy          <= 1'b0;
      lat_we        <= 1'b0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state         <= ISSUE;
            busy          <= 1'b1;
            owner         <= gnt;
            last_grant    <= gnt;
            lat_we        <= sel_we;
            mem_read_req  <= ~sel_we;
            mem_write_req <= sel_we;
            mem_addr      <= sel_addr;
            mem_wdata     <= sel_wdata;
          end
        end
        ISSUE: begin
          mem_read_req  <= 1'b0;
          mem_write_req <= 1'b0;
          state         <= CAPTURE;
        end
        CAPTURE: begin
          // RAM data registered at the ISSUE edge is valid now.
          if (!lat_we) begin
            if (owner) rdata1 <= mem_rdata;
            else       rdata0 <= mem_rdata;
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized bench for ram_arbiter against a transaction-level arbitration model
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00, we = 2'b00, lock = 2'b00;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        ack0, ack1, mem_read_req, mem_write_req, busy, owner;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  ram [256];
  logic [7:0]  shadow [256];
  logic        loaded = 1'b0;
  int          total = 0, bad = 0, cyc = 0;

  int          g_edge = -100;
  bit          g_port, g_we, last_grant = 1'b1;
  logic [31:0] g_rd;
  logic        x_rreq, x_wreq, x_busy, x_owner;
  logic [1:0]  x_ack;
  logic [31:0] x_addr, x_wdata;
  logic [31:0] x_rdata [2];

`ifdef RAM_ARB_LOCK_EN
  int exp_seq [4] = '{1, 1, 1, 0};
`else
  int exp_seq [4] = '{0, 1, 0, 1};
`endif

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0), .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1), .rdata1(rdata1),
    .lock0(lock[0]), .lock1(lock[1]),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h10: return 8'h11;
      'h11: return 8'h22;
      'h12: return 8'h33;
      'h13: return 8'h44;
      'h40: return 8'h55;
      'h41: return 8'h66;
      'h42: return 8'h77;
      'h43: return 8'h88;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  // Byte-addressed little-endian RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
      loaded <= 1'b1;
    end else begin
      if (mem_write_req)
        for (int i = 0; i < 4; i++) ram[8'(mem_addr[7:0] + i)] <= mem_wdata[8*i +: 8];
      if (mem_read_req)
        mem_rdata <= {ram[mem_addr[7:0] + 8'd3], ram[mem_addr[7:0] + 8'd2],
                      ram[mem_addr[7:0] + 8'd1], ram[mem_addr[7:0]]};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    g_edge     = -100;
    g_we       = 1'b0;
    last_grant = 1'b1;
    x_rreq = 0; x_wreq = 0; x_busy = 0; x_owner = 0; x_ack = 2'b00;
    x_addr = '0; x_wdata = '0; x_rdata[0] = '0; x_rdata[1] = '0;
  endtask

  // Transaction-level view: a grant at edge G strobes at G, acks at G+2, re-arbitrates at G+4.
  task automatic predict();
    int   e;
    logic p;
    e = cyc + 1;
    if (!reset) begin
      model_reset();
      return;
    end
    if (e >= g_edge + 4 && req != 2'b00) begin
      p = (req == 2'b11) ? ~last_grant : req[1];
`ifdef RAM_ARB_LOCK_EN
      if (lock[last_grant] && req[last_grant]) p = last_grant;
`endif
      g_port = p; g_we = we[p]; g_edge = e; last_grant = p;
      x_addr = addr[p]; x_wdata = wdata[p]; x_owner = p;
      if (g_we)
        for (int i = 0; i < 4; i++) shadow[8'(addr[p][7:0] + i)] = wdata[p][8*i +: 8];
      else
        g_rd = {shadow[addr[p][7:0] + 8'd3], shadow[addr[p][7:0] + 8'd2],
                shadow[addr[p][7:0] + 8'd1], shadow[addr[p][7:0]]};
    end
    x_rreq = (e == g_edge) && !g_we;
    x_wreq = (e == g_edge) && g_we;
    x_ack  = 2'b00;
    if (e == g_edge + 2) begin
      x_ack[g_port] = 1'b1;
      if (!g_we) x_rdata[g_port] = g_rd;
    end
    x_busy = (e >= g_edge) && (e <= g_edge + 2);
  endtask

  task automatic compare();
    check_eq("mem_read_req", mem_read_req, x_rreq);
    check_eq("mem_write_req", mem_write_req, x_wreq);
    check_eq("mem_addr", mem_addr, x_addr);
    check_eq("mem_wdata", mem_wdata, x_wdata);
    check_eq("ack0", ack0, x_ack[0]);
    check_eq("ack1", ack1, x_ack[1]);
    check_eq("rdata0", rdata0, x_rdata[0]);
    check_eq("rdata1", rdata1, x_rdata[1]);
    check_eq("busy", busy, x_busy);
    check_eq("owner", owner, x_owner);
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic wait_ack(input int p, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(p != 0 ? ack1 : ack0) && lat < 20);
    check_eq("ack_seen", p != 0 ? ack1 : ack0, 1);
  endtask

  task automatic set_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic new_txn(input int p);
    set_txn(p, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int lat, n, n1;
    int seq [4];
    int t [4];
    logic p;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_byte(i);

    tick();
    tick();
    reset = 1'b1;
    tick();

    // single read on port 0
    set_txn(0, 1'b0, 32'h10, 32'h0);
    tick();
    check_eq("rd_strobe", mem_read_req, 1);
    check_eq("rd_addr", mem_addr, 32'h10);
    wait_ack(0, lat);
    check_eq("rd_latency", lat + 1, 3);
    check_eq("rd_data", rdata0, 32'h44332211);
    req[0] = 1'b0;
    tick();

    // single write on port 1
    set_txn(1, 1'b1, 32'h20, 32'hDEADBEEF);
    tick();
    check_eq("wr_strobe", {mem_write_req, mem_read_req}, 2'b10);
    check_eq("wr_wdata", mem_wdata, 32'hDEADBEEF);
    wait_ack(1, lat);
    check_eq("wr_latency", lat + 1, 3);
    req[1] = 1'b0;
    tick();
    check_eq("wr_ram", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'hDEADBEEF);
    check_eq("wr_rdata1", rdata1, 32'h0);

    // fields changed while the read is in flight must be ignored
    set_txn(0, 1'b0, 32'h10, 32'h0);
    tick();
    set_txn(0, 1'b1, 32'h40, 32'h12345678);
    wait_ack(0, lat);
    check_eq("fc_data", rdata0, 32'h44332211);
    req[0] = 1'b0;
    tick();

    // reset during CAPTURE of a port-0 read
    set_txn(0, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    req[0] = 1'b0;
    #1;
    model_reset();
    compare();
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    tick();
    reset = 1'b1;
    set_txn(0, 1'b0, 32'h40, 32'h0);
    wait_ack(0, lat);
    check_eq("rst_after_data", rdata0, 32'h88776655);
    req[0] = 1'b0;
    tick();

    // contention, with lock1 held until port 1's third completion
    pulse_reset();
    set_txn(0, 1'b0, $urandom, 32'h0);
    set_txn(1, 1'b0, $urandom, 32'h0);
    lock = 2'b10;
    n = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin seq[i] = -1; t[i] = 0; end
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (ack0 || ack1) begin
        p = ack1;
        seq[n] = int'(p);
        t[n] = cyc;
        n++;
        if (p) n1++;
        if (n1 == 3) lock[1] = 1'b0;
        addr[p] = $urandom;
      end
    end
    check_eq("cont_count", n, 4);
    for (int i = 0; i < 4; i++) check_eq("cont_seq", seq[i], exp_seq[i]);
    for (int i = 1; i < 4; i++) check_eq("cont_gap", t[i] - t[i-1], 4);
    req = 2'b00;
    lock = 2'b00;
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int q = 0; q < 2; q++) begin
        if (q != 0 ? ack1 : ack0) begin
          if ($urandom_range(0, 9) < 6) new_txn(q);
          else req[q] = 1'b0;
        end else if (!req[q]) begin
          if ($urandom_range(0, 3) == 0) new_txn(q);
        end else if (int'(g_port) == q && cyc >= g_edge && cyc <= g_edge + 1 &&
                     $urandom_range(0, 1) == 1) begin
          addr[q] = $urandom;
          wdata[q] = $urandom;
          we[q] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) lock[q] = ~lock[q];
      end
      tick();
    end
    req = 2'b00;
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
